phase_control_unit: RTL and testbench
=====================================

// Module: phase_control_unit
// PURPOSE
// Consumes the one-hot fetch/decode/execute/writeback phase strobes from the phase sequencer.
// Turns them into datapath control for the 8-bit CPU:
// - PC and instruction register (IR)
// - immediate latch and memory data register (MDR)
// - memory address/write, ALU op, register-file write, halt.
// Memory read is combinational: mem_rdata is valid in the same cycle as mem_addr.
// PARAMETERS
// RESET_PC  8'h00  PC value loaded on reset
// PORTS
// clock        in   1  system clock, rising edge
// reset        in   1  asynchronous, active-high
// fetch        in   1  phase strobe: fetch
// decode       in   1  phase strobe: decode
// execute      in   1  phase strobe: execute
// writeback    in   1  phase strobe: writeback
// mem_rdata    in   8  memory read data
// zero_flag    in   1  registered Z flag from flag register
// carry_flag   in   1  registered C flag from flag register
// mem_addr     out  8  memory address
// mem_we       out  1  memory write enable (write data = register rs)
// pc           out  8  program counter
// rd_sel       out  2  destination/A-operand register = IR[3:2]
// rs_sel       out  2  source/B-operand register = IR[1:0]
// alu_op       out  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT, 6 PASS_B
// flag_we      out  1  latch ALU Z/C into flag register
// reg_we       out  1  register-file write enable
// wdata_sel    out  2  write source: 0 ALU, 1 imm, 2 mdr, 3 rs
// imm          out  8  immediate/address operand latch
// mdr          out  8  memory data register
// halted       out  1  CPU halted (sticky until reset)
// phase_error  out  1  illegal strobe pattern seen (sticky until reset)
// BEHAVIOUR
// ISA: IR[7:4] is the opcode.
// - 0 NOP, 1 MOV, 2 LDI, 3 LD, 4 ST, 5 ADD, 6 SUB, 7 AND
// - 8 OR, 9 XOR, A NOT, B JMP, C JZ, D JC, E CMP, F HLT
// - Opcodes 2, 3, 4, B, C, D carry a second (immediate) byte.
// Reset: pc=RESET_PC; IR, imm, mdr = 0; halted, phase_error = 0.
//   Every output is 0 except pc. Reset mid-instruction abandons it; no partial writes.
// Idle: all strobes 0 (sequencer reset recovery) -> no state change, all enables 0.
// Legal order: fetch -> decode -> execute -> writeback -> fetch.
// The first strobe after reset must be fetch.
// Violations:
// - >1 strobe high, or an out-of-order strobe -> phase_error set at that edge.
// - The violating cycle performs no action; enables are 0 in that cycle.
// - Subsequent legal cycles continue, resynchronising at the next fetch.
// Per-phase action. "Edge" = the rising edge that ends the phase cycle:
// - fetch: mem_addr=pc. Edge: IR<=mem_rdata, pc<=pc+1.
// - decode: mem_addr=pc. Imm opcodes at edge: imm<=mem_rdata, pc<=pc+1. Other opcodes: imm unchanged.
// - execute:
//   - LD: mem_addr=imm; edge: mdr<=mem_rdata.
//   - ST: mem_addr=imm, mem_we=1 for this cycle only.
//   - ALU ops 5-A and E: alu_op valid, flag_we=1.
//   - JMP: pc<=imm at edge.
//   - JZ/JC: pc<=imm at edge if zero_flag/carry_flag is 1.
//   - HLT: halted<=1 at edge.
// - writeback: reg_we=1 for 1,2,3,5-A. wdata_sel: MOV=3, LDI=1, LD=2, ALU ops=0. CMP writes no register.
// Outside execute/writeback, mem_addr=pc.
// rd_sel, rs_sel, alu_op are combinational from IR; held stable from decode through writeback.
// pc arithmetic is modulo 256: 8'hFF+1 -> 8'h00, including within a 2-byte instruction.
// Halted: every strobe ignored; pc, IR, imm, mdr frozen; all enables 0; only reset clears it.
// Simultaneous reset and strobe: reset wins.
// TESTING
// Reset mid-execute of ST: no mem_we pulse; pc=RESET_PC; all outputs 0; next fetch reads addr 0.
// Program LDI r1,0x05; LDI r2,0x03; ADD r1,r2:
// - pc steps 0->2->4->5.
// - Writebacks: r1=0x05 (sel 1), then r2=0x03 (sel 1), then r1=ALU (sel 0, alu_op 0).
// - flag_we=1 only in the ADD execute cycle.
// JZ 0x40 with zero_flag=1 -> pc=0x40 after execute; with zero_flag=0 -> pc=0x02.
// LD r0,[0x80] with mem[0x80]=0xA5 -> mem_addr=0x80 in execute; mdr=0xA5; reg_we, wdata_sel=2 in writeback.
// pc=0xFF fetching LDI -> imm read from 0x00, pc=0x01. HLT -> halted=1; further strobes leave pc constant.
// fetch+decode both high -> phase_error=1, no IR/pc change. decode right after reset -> phase_error=1.

Source files
------------

// File: rtl/phase_control_if.sv
// Bundle between the phase sequencer / memory / register file and the phase control unit.
// The control unit takes the slave view; the sequencer side (or a bench) takes the master view.
interface phase_control_if;
  logic       fetch;
  logic       decode;
  logic       execute;
  logic       writeback;
  logic [7:0] mem_rdata;
  logic       zero_flag;
  logic       carry_flag;
  logic [7:0] mem_addr;
  logic       mem_we;
  logic [7:0] pc;
  logic [1:0] rd_sel;
  logic [1:0] rs_sel;
  logic [2:0] alu_op;
  logic       flag_we;
  logic       reg_we;
  logic [1:0] wdata_sel;
  logic [7:0] imm;
  logic [7:0] mdr;
  logic       halted;
  logic       phase_error;

  modport slave (
    input  fetch, decode, execute, writeback, mem_rdata, zero_flag, carry_flag,
    output mem_addr, mem_we, pc, rd_sel, rs_sel, alu_op, flag_we, reg_we,
           wdata_sel, imm, mdr, halted, phase_error
  );

  modport master (
    output fetch, decode, execute, writeback, mem_rdata, zero_flag, carry_flag,
    input  mem_addr, mem_we, pc, rd_sel, rs_sel, alu_op, flag_we, reg_we,
           wdata_sel, imm, mdr, halted, phase_error
  );
endinterface

// File: rtl/phase_control_unit.sv
// Phase-driven control unit for the 8-bit CPU: turns one-hot sequencer strobes into
// PC/IR/immediate/MDR updates and per-cycle datapath enables.
module phase_control_unit #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input logic            clock,
  input logic            reset,
  phase_control_if.slave bus
);

  typedef enum logic [1:0] {
    EXPECT_FETCH,
    EXPECT_DECODE,
    EXPECT_EXECUTE,
    EXPECT_WRITEBACK
  } phase_t;

  phase_t     state_q, state_d;
  logic [7:0] pc_q, ir_q, imm_q, mdr_q;
  logic       halted_q, error_q;
  logic [3:0] strobes, opcode;
  logic       legal, violation;
  logic       do_fetch, do_decode, do_execute, do_writeback;
  logic       has_imm, is_alu, writes_reg, uses_imm_addr;
  logic [2:0] alu_op;
  logic [1:0] wdata_sel;

  assign strobes       = {bus.writeback, bus.execute, bus.decode, bus.fetch};
  assign opcode        = ir_q[7:4];
  assign uses_imm_addr = (opcode == 4'h3) || (opcode == 4'h4);

  // Instruction classification; CMP is an ALU op (SUB) that only updates flags.
  always_comb begin
    has_imm    = 1'b0;
    is_alu     = 1'b0;
    writes_reg = 1'b0;
    alu_op     = 3'd0;
    wdata_sel  = 2'd0;
    case (opcode)
      4'h1: begin writes_reg = 1'b1; wdata_sel = 2'd3; end
      4'h2: begin has_imm = 1'b1; writes_reg = 1'b1; wdata_sel = 2'd1; end
      4'h3: begin has_imm = 1'b1; writes_reg = 1'b1; wdata_sel = 2'd2; end
      4'h4, 4'hB, 4'hC, 4'hD: has_imm = 1'b1;
      4'h5: begin is_alu = 1'b1; writes_reg = 1'b1; alu_op = 3'd0; end
      4'h6: begin is_alu = 1'b1; writes_reg = 1'b1; alu_op = 3'd1; end
      4'h7: begin is_alu = 1'b1; writes_reg = 1'b1; alu_op = 3'd2; end
      4'h8: begin is_alu = 1'b1; writes_reg = 1'b1; alu_op = 3'd3; end
      4'h9: begin is_alu = 1'b1; writes_reg = 1'b1; alu_op = 3'd4; end
      4'hA: begin is_alu = 1'b1; writes_reg = 1'b1; alu_op = 3'd5; end
      4'hE: begin is_alu = 1'b1; alu_op = 3'd1; end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= EXPECT_FETCH;
    else       state_q <= state_d;
  end

  // A strobe is acted on only if it is the single expected one; anything else
  // is a violation that does nothing and forces a resync on the next fetch.
  always_comb begin
    state_d      = state_q;
    do_fetch     = 1'b0;
    do_decode    = 1'b0;
    do_execute   = 1'b0;
    do_writeback = 1'b0;
    violation    = 1'b0;
    legal        = (strobes == (4'b0001 << state_q));
    if (!halted_q && (strobes != 4'b0000)) begin
      if (legal) begin
        case (state_q)
          EXPECT_FETCH:     begin do_fetch     = 1'b1; state_d = EXPECT_DECODE;    end
          EXPECT_DECODE:    begin do_decode    = 1'b1; state_d = EXPECT_EXECUTE;   end
          EXPECT_EXECUTE:   begin do_execute   = 1'b1; state_d = EXPECT_WRITEBACK; end
          EXPECT_WRITEBACK: begin do_writeback = 1'b1; state_d = EXPECT_FETCH;     end
        endcase
      end else begin
        violation = 1'b1;
        state_d   = EXPECT_FETCH;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      ir_q     <= 8'h00;
      imm_q    <= 8'h00;
      mdr_q    <= 8'h00;
      halted_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      if (violation) error_q <= 1'b1;
      if (do_fetch) begin
        ir_q <= bus.mem_rdata;
        pc_q <= pc_q + 8'd1;
      end
      if (do_decode && has_imm) begin
        imm_q <= bus.mem_rdata;
        pc_q  <= pc_q + 8'd1;
      end
      if (do_execute) begin
        case (opcode)
          4'h3: mdr_q <= bus.mem_rdata;
          4'hB: pc_q  <= imm_q;
          4'hC: if (bus.zero_flag)  pc_q <= imm_q;
          4'hD: if (bus.carry_flag) pc_q <= imm_q;
          4'hF: halted_q <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign bus.mem_addr    = (do_execute && uses_imm_addr) ? imm_q : pc_q;
  assign bus.mem_we      = do_execute && (opcode == 4'h4);
  assign bus.flag_we     = do_execute && is_alu;
  assign bus.reg_we      = do_writeback && writes_reg;
  assign bus.pc          = pc_q;
  assign bus.rd_sel      = ir_q[3:2];
  assign bus.rs_sel      = ir_q[1:0];
  assign bus.alu_op      = alu_op;
  assign bus.wdata_sel   = wdata_sel;
  assign bus.imm         = imm_q;
  assign bus.mdr         = mdr_q;
  assign bus.halted      = halted_q;
  assign bus.phase_error = error_q;

endmodule

// File: tb/tb_phase_control_unit.sv
// Bench for phase_control_unit: directed ISA scenarios plus random strobe/program runs
// compared against an instruction-level reference model of the control unit.
module tb_phase_control_unit;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  phase_control_if bus();

  phase_control_unit #(.RESET_PC(8'h00)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  logic [7:0] mem [256];
  assign bus.mem_rdata = mem[bus.mem_addr];

  int errors = 0;
  int checks = 0;

  localparam logic [3:0] F = 4'b0001, D = 4'b0010, E = 4'b0100, W = 4'b1000;

  // Opcode -> alu_op and opcode -> wdata_sel lookup, straight from the ISA table
  logic [2:0] alu_tab  [16] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd2,
                                3'd3, 3'd4, 3'd5, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0};
  logic [1:0] wsel_tab [16] = '{2'd0, 2'd3, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0,
                                2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};

  logic [7:0] m_pc, m_ir, m_imm, m_mdr;
  logic       m_halt, m_err;
  int         m_next;
  logic [7:0] e_addr;
  logic       e_we, e_flag_we, e_reg_we;
  logic [2:0] e_alu;
  logic [1:0] e_wsel, e_rd, e_rs;

  logic [7:0] o_addr;
  logic       o_we, o_flag_we, o_reg_we;
  logic [2:0] o_alu;
  logic [1:0] o_wsel, o_rd, o_rs;

  logic [7:0] ph_addr [4];
  logic       ph_flag [4];
  logic       ph_reg  [4];
  logic [1:0] ph_wsel [4];
  logic [2:0] ph_alu  [4];
  logic [1:0] ph_rd   [4];
  logic [7:0] ph_pc   [4];

  task automatic model_reset();
    m_pc = 8'h00; m_ir = 8'h00; m_imm = 8'h00; m_mdr = 8'h00;
    m_halt = 1'b0; m_err = 1'b0; m_next = 0;
  endtask

  // One sequencer cycle at instruction level: expected outputs, then the architectural update
  task automatic model_cycle(input logic [3:0] s);
    int op, idx;
    bit legal;
    op  = int'(m_ir[7:4]);
    idx = s[0] ? 0 : s[1] ? 1 : s[2] ? 2 : 3;
    legal = !m_halt && ($countones(s) == 1) && (idx == m_next);
    e_alu = alu_tab[op]; e_wsel = wsel_tab[op]; e_rd = m_ir[3:2]; e_rs = m_ir[1:0];
    e_addr = m_pc; e_we = 1'b0; e_flag_we = 1'b0; e_reg_we = 1'b0;
    if (legal) begin
      case (idx)
        0: begin m_ir = mem[m_pc]; m_pc = m_pc + 8'd1; end
        1: if (op inside {2, 3, 4, 11, 12, 13}) begin m_imm = mem[m_pc]; m_pc = m_pc + 8'd1; end
        2: begin
          if (op == 3 || op == 4) e_addr = m_imm;
          e_we      = (op == 4);
          e_flag_we = (op inside {[5:10], 14});
          if (op == 3) m_mdr = mem[m_imm];
          if (op == 11 || (op == 12 && bus.zero_flag) || (op == 13 && bus.carry_flag)) m_pc = m_imm;
          if (op == 15) m_halt = 1'b1;
        end
        default: e_reg_we = (op inside {1, 2, 3, [5:10]});
      endcase
      m_next = (idx + 1) % 4;
    end else if (!m_halt && s != 4'b0000) begin
      m_err  = 1'b1;
      m_next = 0;
    end
  endtask

  task automatic drive_cycle(input logic [3:0] s);
    @(negedge clock);
    {bus.writeback, bus.execute, bus.decode, bus.fetch} = s;
    model_cycle(s);
    #2;
    o_addr = bus.mem_addr; o_we = bus.mem_we; o_flag_we = bus.flag_we; o_reg_we = bus.reg_we;
    o_alu = bus.alu_op; o_wsel = bus.wdata_sel; o_rd = bus.rd_sel; o_rs = bus.rs_sel;
    @(posedge clock);
    #1;
  endtask

  task automatic run_instr();
    for (int p = 0; p < 4; p++) begin
      drive_cycle(4'b0001 << p);
      ph_addr[p] = o_addr; ph_flag[p] = o_flag_we; ph_reg[p] = o_reg_we;
      ph_wsel[p] = o_wsel; ph_alu[p] = o_alu; ph_rd[p] = o_rd; ph_pc[p] = bus.pc;
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    {bus.writeback, bus.execute, bus.decode, bus.fetch} = 4'b0000;
    @(posedge clock);
    #1;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.pc !== 8'h00) begin errors++; $display("FAIL reset_pc: got %h expected 00", bus.pc); end
    checks++;
    if ({bus.mem_addr, bus.mem_we, bus.rd_sel, bus.rs_sel, bus.alu_op, bus.flag_we, bus.reg_we,
         bus.wdata_sel, bus.imm, bus.mdr, bus.halted, bus.phase_error} !== 38'd0) begin
      errors++;
      $display("FAIL reset_outputs: got nonzero outputs imm=%h mdr=%h halted=%b perr=%b, expected all 0",
               bus.imm, bus.mdr, bus.halted, bus.phase_error);
    end
    drive_cycle(4'b0000);
    checks++;
    if ({bus.pc, o_we, o_flag_we, o_reg_we, bus.phase_error} !== 12'd0) begin
      errors++;
      $display("FAIL idle_cycle: got pc=%h we=%b fwe=%b rwe=%b perr=%b expected all 0",
               bus.pc, o_we, o_flag_we, o_reg_we, bus.phase_error);
    end
  endtask

  task automatic test_reset_mid_store();
    do_reset();
    mem[8'h00] = 8'h41; mem[8'h01] = 8'h90;
    drive_cycle(F);
    drive_cycle(D);
    @(negedge clock);
    bus.execute = 1'b1;
    reset = 1'b1;
    #2;
    checks++;
    if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rst_st_we: got %b expected 0", bus.mem_we); end
    checks++;
    if ({bus.pc, bus.mem_addr, bus.imm, bus.rs_sel, bus.halted, bus.phase_error} !== 28'd0) begin
      errors++;
      $display("FAIL rst_st_outputs: got pc=%h addr=%h imm=%h rs=%0d expected all 0",
               bus.pc, bus.mem_addr, bus.imm, bus.rs_sel);
    end
    @(posedge clock);
    #1;
    @(negedge clock);
    reset = 1'b0;
    bus.execute = 1'b0;
    model_reset();
    drive_cycle(F);
    checks++;
    if (o_addr !== 8'h00) begin errors++; $display("FAIL rst_st_refetch_addr: got %h expected 00", o_addr); end
    checks++;
    if (bus.pc !== 8'h01) begin errors++; $display("FAIL rst_st_refetch_pc: got %h expected 01", bus.pc); end
  endtask

  task automatic test_program();
    do_reset();
    mem[0] = 8'h24; mem[1] = 8'h05; mem[2] = 8'h28; mem[3] = 8'h03; mem[4] = 8'h56;
    run_instr();
    checks++;
    if ({ph_pc[3], ph_reg[3], ph_wsel[3], ph_rd[3], ph_flag[2]} !== {8'h02, 1'b1, 2'd1, 2'd1, 1'b0}) begin
      errors++;
      $display("FAIL prog_ldi_r1: got pc=%h rwe=%b sel=%0d rd=%0d fwe=%b expected pc=02 rwe=1 sel=1 rd=1 fwe=0",
               ph_pc[3], ph_reg[3], ph_wsel[3], ph_rd[3], ph_flag[2]);
    end
    run_instr();
    checks++;
    if ({ph_pc[3], ph_reg[3], ph_wsel[3], ph_rd[3], bus.imm} !== {8'h04, 1'b1, 2'd1, 2'd2, 8'h03}) begin
      errors++;
      $display("FAIL prog_ldi_r2: got pc=%h rwe=%b sel=%0d rd=%0d imm=%h expected pc=04 rwe=1 sel=1 rd=2 imm=03",
               ph_pc[3], ph_reg[3], ph_wsel[3], ph_rd[3], bus.imm);
    end
    run_instr();
    checks++;
    if ({ph_pc[3], ph_reg[3], ph_wsel[3], ph_rd[3], ph_alu[3]} !== {8'h05, 1'b1, 2'd0, 2'd1, 3'd0}) begin
      errors++;
      $display("FAIL prog_add: got pc=%h rwe=%b sel=%0d rd=%0d alu=%0d expected pc=05 rwe=1 sel=0 rd=1 alu=0",
               ph_pc[3], ph_reg[3], ph_wsel[3], ph_rd[3], ph_alu[3]);
    end
    checks++;
    if ({ph_flag[0], ph_flag[1], ph_flag[2], ph_flag[3]} !== 4'b0010) begin
      errors++;
      $display("FAIL prog_add_flag_we: got f/d/e/w=%b%b%b%b expected 0010",
               ph_flag[0], ph_flag[1], ph_flag[2], ph_flag[3]);
    end
  endtask

  task automatic test_jz();
    for (int zf = 1; zf >= 0; zf--) begin
      do_reset();
      mem[0] = 8'hC0; mem[1] = 8'h40;
      bus.zero_flag = 1'(zf);
      run_instr();
      checks++;
      if (ph_pc[2] !== ((zf == 1) ? 8'h40 : 8'h02)) begin
        errors++;
        $display("FAIL jz_pc zf=%0d: got %h expected %h", zf, ph_pc[2], (zf == 1) ? 8'h40 : 8'h02);
      end
    end
    bus.zero_flag = 1'b0;
  endtask

  task automatic test_ld();
    do_reset();
    mem[0] = 8'h30; mem[1] = 8'h80; mem[8'h80] = 8'hA5;
    run_instr();
    checks++;
    if (ph_addr[2] !== 8'h80) begin errors++; $display("FAIL ld_addr: got %h expected 80", ph_addr[2]); end
    checks++;
    if (bus.mdr !== 8'hA5) begin errors++; $display("FAIL ld_mdr: got %h expected a5", bus.mdr); end
    checks++;
    if ({ph_reg[3], ph_wsel[3]} !== {1'b1, 2'd2}) begin
      errors++;
      $display("FAIL ld_wb: got rwe=%b sel=%0d expected rwe=1 sel=2", ph_reg[3], ph_wsel[3]);
    end
  endtask

  task automatic test_wrap_halt();
    do_reset();
    mem[0] = 8'hB0; mem[1] = 8'hFF; mem[8'hFF] = 8'h24;
    run_instr();
    checks++;
    if (bus.pc !== 8'hFF) begin errors++; $display("FAIL jmp_pc: got %h expected ff", bus.pc); end
    drive_cycle(F);
    checks++;
    if (bus.pc !== 8'h00) begin errors++; $display("FAIL wrap_fetch_pc: got %h expected 00", bus.pc); end
    drive_cycle(D);
    checks++;
    if ({bus.imm, bus.pc} !== {8'hB0, 8'h01}) begin
      errors++;
      $display("FAIL wrap_imm: got imm=%h pc=%h expected imm=b0 pc=01", bus.imm, bus.pc);
    end
    drive_cycle(E);
    drive_cycle(W);
    run_instr();
    checks++;
    if ({bus.halted, bus.pc} !== {1'b1, 8'h02}) begin
      errors++;
      $display("FAIL hlt: got halted=%b pc=%h expected halted=1 pc=02", bus.halted, bus.pc);
    end
    for (int c = 0; c < 6; c++) begin
      drive_cycle(4'b0001 << (c % 4));
      checks++;
      if ({bus.pc, bus.halted, o_we, o_flag_we, o_reg_we, bus.phase_error} !== {8'h02, 1'b1, 4'b0000}) begin
        errors++;
        $display("FAIL halted_frozen c=%0d: got pc=%h halted=%b we=%b fwe=%b rwe=%b perr=%b expected pc=02 halted=1 rest 0",
                 c, bus.pc, bus.halted, o_we, o_flag_we, o_reg_we, bus.phase_error);
      end
    end
  endtask

  task automatic test_phase_errors();
    do_reset();
    mem[0] = 8'h5F;
    drive_cycle(F | D);
    checks++;
    if ({bus.phase_error, bus.pc, bus.rd_sel} !== {1'b1, 8'h00, 2'd0}) begin
      errors++;
      $display("FAIL multi_strobe: got perr=%b pc=%h rd=%0d expected perr=1 pc=00 rd=0",
               bus.phase_error, bus.pc, bus.rd_sel);
    end
    drive_cycle(F);
    checks++;
    if ({bus.phase_error, bus.pc, bus.rd_sel} !== {1'b1, 8'h01, 2'd3}) begin
      errors++;
      $display("FAIL resync_fetch: got perr=%b pc=%h rd=%0d expected perr=1 pc=01 rd=3",
               bus.phase_error, bus.pc, bus.rd_sel);
    end
    do_reset();
    drive_cycle(D);
    checks++;
    if ({bus.phase_error, bus.pc, bus.imm} !== {1'b1, 8'h00, 8'h00}) begin
      errors++;
      $display("FAIL decode_after_reset: got perr=%b pc=%h imm=%h expected perr=1 pc=00 imm=00",
               bus.phase_error, bus.pc, bus.imm);
    end
  endtask

  task automatic test_random();
    logic [3:0] s;
    for (int round = 0; round < 4; round++) begin
      for (int a = 0; a < 256; a++) begin
        mem[a] = 8'($urandom);
        if (mem[a][7:4] == 4'hF && $urandom_range(0, 3) != 0) mem[a][7:4] = 4'h5;
      end
      do_reset();
      for (int c = 0; c < 300; c++) begin
        bus.zero_flag  = 1'($urandom);
        bus.carry_flag = 1'($urandom);
        if ($urandom_range(0, 19) == 0) s = 4'($urandom);
        else                            s = 4'b0001 << m_next;
        drive_cycle(s);
        checks++;
        if ({o_addr, o_we, o_flag_we, o_reg_we} !== {e_addr, e_we, e_flag_we, e_reg_we}) begin
          errors++;
          $display("FAIL rnd_enables r%0d c%0d s=%b: got addr=%h we=%b fwe=%b rwe=%b expected addr=%h we=%b fwe=%b rwe=%b",
                   round, c, s, o_addr, o_we, o_flag_we, o_reg_we, e_addr, e_we, e_flag_we, e_reg_we);
        end
        checks++;
        if ({o_alu, o_wsel, o_rd, o_rs} !== {e_alu, e_wsel, e_rd, e_rs}) begin
          errors++;
          $display("FAIL rnd_decode r%0d c%0d: got alu=%0d sel=%0d rd=%0d rs=%0d expected alu=%0d sel=%0d rd=%0d rs=%0d",
                   round, c, o_alu, o_wsel, o_rd, o_rs, e_alu, e_wsel, e_rd, e_rs);
        end
        checks++;
        if ({bus.pc, bus.imm, bus.mdr, bus.halted, bus.phase_error} !== {m_pc, m_imm, m_mdr, m_halt, m_err}) begin
          errors++;
          $display("FAIL rnd_state r%0d c%0d: got pc=%h imm=%h mdr=%h halt=%b perr=%b expected pc=%h imm=%h mdr=%h halt=%b perr=%b",
                   round, c, bus.pc, bus.imm, bus.mdr, bus.halted, bus.phase_error,
                   m_pc, m_imm, m_mdr, m_halt, m_err);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    {bus.writeback, bus.execute, bus.decode, bus.fetch} = 4'b0000;
    bus.zero_flag = 1'b0;
    bus.carry_flag = 1'b0;
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    model_reset();
    repeat (2) @(posedge clock);
    test_reset();
    test_reset_mid_store();
    test_program();
    test_jz();
    test_ld();
    test_wrap_halt();
    test_phase_errors();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
